ram_stream_loader: RTL and testbench
====================================

Name: ram_stream_loader

Overview:
Write-side companion to the display-scan RAM reader: accepts a byte stream over a valid/ready handshake and writes it into the 32x8 dual-port RAM write port (wraddress/data/wren) at an auto-incrementing address. It also supports a bulk zero-fill (CLEAR) and an explicit pointer load. It sits between the input source (switches/keys or a UART receiver) and the RAM. The read side keeps scanning independently on its own seconds tick.

Parameters:
ADDR_W, 5, RAM address width.
DATA_W, 8, RAM data width.
DEPTH, 32, number of RAM words; must equal 2**ADDR_W.
WRAP, 0, 0 = stop and assert FULL after DEPTH writes; 1 = pointer wraps and FULL never asserts.

Ports:
CLK  in  1  system clock; all state on posedge.
RESET  in  1  reset, synchronous, active-high.
IN_DATA  in  DATA_W  stream byte.
IN_VALID  in  1  IN_DATA valid.
IN_READY  out  1  loader can accept a byte this cycle.
CLEAR  in  1  request zero-fill of the whole RAM.
LOAD_ADDR  in  1  load write pointer from SET_ADDR.
SET_ADDR  in  ADDR_W  new pointer value.
WRADDRESS  out  ADDR_W  RAM write address (registered).
WRDATA  out  DATA_W  RAM write data (registered).
WREN  out  1  RAM write enable (registered, 1-cycle pulse per word).
PTR  out  ADDR_W  current write pointer (next address to be written).
COUNT  out  ADDR_W+1  words written since last reset/clear, saturates at DEPTH.
FULL  out  1  COUNT==DEPTH and WRAP==0.
BUSY  out  1  high while in CLEAR state.

Behaviour:
- RESET (sync, active-high): state=IDLE; PTR=0, COUNT=0, FULL=0, BUSY=0, WREN=0, WRADDRESS=0, WRDATA=0. RESET mid-CLEAR aborts the fill; RAM contents are left as partially cleared.
- States: IDLE, CLEAR. No other states.
- IN_READY = (state==IDLE) && !FULL && !CLEAR && !LOAD_ADDR. This is combinational from registers and the two control inputs, with no dependency on IN_VALID.
- Accept: IN_VALID && IN_READY at a posedge. On the same edge: WRADDRESS<=PTR, WRDATA<=IN_DATA, WREN<=1, PTR<=PTR+1 (mod DEPTH), COUNT<=min(COUNT+1, DEPTH). Latency from accept edge to RAM write edge is 1 cycle. Back-to-back accepts give one write per cycle.
- WREN is 0 in every cycle without an accept or a clear write.
- FULL (WRAP=0): goes high on the edge where COUNT reaches DEPTH. PTR has then wrapped to 0 and IN_READY drops. Only CLEAR or RESET clears FULL. LOAD_ADDR does not clear FULL.
- WRAP=1: PTR wraps DEPTH-1 -> 0 and writing continues. COUNT saturates at DEPTH. FULL is held at 0.
- LOAD_ADDR in IDLE (CLEAR low): PTR<=SET_ADDR; COUNT unchanged; no write. It has priority over IN_VALID because IN_READY is low in that cycle.
- CLEAR in IDLE: state<=CLEAR, BUSY<=1, internal clear index=0. It has priority over LOAD_ADDR and IN_VALID.
- CLEAR state: each cycle WRADDRESS<=index, WRDATA<=0, WREN<=1, index++. After index DEPTH-1 is issued: state<=IDLE, BUSY<=0, PTR<=0, COUNT<=0, FULL<=0.
  - WREN is high for exactly DEPTH consecutive cycles.
  - IN_READY is low throughout.
  - CLEAR, LOAD_ADDR and IN_VALID are ignored while BUSY.
- CLEAR held high across the return to IDLE starts a new fill on the next edge (level sensitive).
- All arithmetic is unsigned. PTR increment is modulo 2**ADDR_W. COUNT is ADDR_W+1 bits so that DEPTH is representable.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_CLEAR) and default widths ADDR_W/DATA_W/DEPTH, also used by the RAM wrapper and the display scanner.
- No sub-module required. Optional small sub-module "wr_pointer" (load/increment/wrap counter) is reused for both PTR and the clear index.

Test Plan:
- Reset then stream 0xA0..0xA4 with IN_VALID held high for 5 cycles -> WREN high 5 cycles, one cycle after each accept, with WRADDRESS 0..4 and WRDATA 0xA0..0xA4; PTR=5, COUNT=5.
- WRAP=0, stream 32 bytes -> on the 32nd accept edge FULL=1, COUNT=32, PTR=0, IN_READY=0; a 33rd IN_VALID produces no WREN.
- WRAP=1, stream 34 bytes -> writes land on addresses 0..31,0,1; COUNT=32; FULL stays 0.
- From FULL, pulse CLEAR for 1 cycle -> BUSY high 32 cycles, WREN high 32 consecutive cycles with WRADDRESS 0..31 and WRDATA=0; then FULL=0, COUNT=0, PTR=0, IN_READY=1.
- CLEAR and IN_VALID asserted in the same cycle -> IN_READY=0 and the byte is not written; fill starts. Separately, LOAD_ADDR=1 with SET_ADDR=0x1C, then stream 0x55 -> write at address 0x1C, PTR=0x1D.
- Assert RESET at clear index 10 -> next cycle BUSY=0, WREN=0, PTR=0, COUNT=0, state IDLE.

Source files
------------

// File: rtl/ram_stream_loader_pkg.sv
// Shared definitions for the display RAM: default geometry and loader state encoding.
// The RAM wrapper and display scanner pick up the same widths from here.
package ram_stream_loader_pkg;

    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_DEPTH  = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } loader_state_t;

endpackage

// File: rtl/ram_stream_loader_wr_pointer.sv
// Loadable up-counter that wraps naturally at 2**W.
// Serves as both the stream write pointer and the zero-fill index.
module ram_stream_loader_wr_pointer #(
    parameter int W = 5
)(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Load wins over increment so an end-of-fill pointer reset cannot be lost.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/ram_stream_loader.sv
// Byte-stream writer for the 32x8 display RAM write port: auto-incrementing
// pointer, explicit pointer load, and a whole-RAM zero fill.
module ram_stream_loader
    import ram_stream_loader_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = RAM_DEPTH,
    parameter bit WRAP   = 1'b0
)(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              CLEAR,
    input  logic              LOAD_ADDR,
    input  logic [ADDR_W-1:0] SET_ADDR,
    output logic [ADDR_W-1:0] WRADDRESS,
    output logic [DATA_W-1:0] WRDATA,
    output logic              WREN,
    output logic [ADDR_W-1:0] PTR,
    output logic [ADDR_W:0]   COUNT,
    output logic              FULL,
    output logic              BUSY
);

    localparam logic [ADDR_W:0]   DEPTH_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_INDEX  = ADDR_W'(DEPTH - 1);

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] ptr, clr_idx, ptr_load_value;
    logic              ptr_load, ptr_inc, idx_load, idx_inc;
    logic              wren_next;
    logic [ADDR_W-1:0] wraddress_next;
    logic [DATA_W-1:0] wrdata_next;
    logic [ADDR_W:0]   count, count_next;
    logic              full, full_next, busy, busy_next;
    logic              accept;

    assign IN_READY = (state == ST_IDLE) && !full && !CLEAR && !LOAD_ADDR;
    assign accept   = IN_VALID && IN_READY;
    assign PTR      = ptr;
    assign COUNT    = count;
    assign FULL     = full;
    assign BUSY     = busy;

    ram_stream_loader_wr_pointer #(.W(ADDR_W)) u_ptr (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (ptr_load),
        .load_value (ptr_load_value),
        .inc        (ptr_inc),
        .value      (ptr)
    );

    ram_stream_loader_wr_pointer #(.W(ADDR_W)) u_clr_idx (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (idx_load),
        .load_value ('0),
        .inc        (idx_inc),
        .value      (clr_idx)
    );

    // CLEAR outranks LOAD_ADDR, which outranks a stream byte; nothing is heard while filling.
    always_comb begin
        state_next     = state;
        ptr_load       = 1'b0;
        ptr_load_value = SET_ADDR;
        ptr_inc        = 1'b0;
        idx_load       = 1'b0;
        idx_inc        = 1'b0;
        wren_next      = 1'b0;
        wraddress_next = WRADDRESS;
        wrdata_next    = WRDATA;
        count_next     = count;
        full_next      = full;
        busy_next      = busy;

        case (state)
            ST_IDLE: begin
                if (CLEAR) begin
                    state_next = ST_CLEAR;
                    busy_next  = 1'b1;
                    idx_load   = 1'b1;
                end else if (LOAD_ADDR) begin
                    ptr_load = 1'b1;
                end else if (accept) begin
                    wren_next      = 1'b1;
                    wraddress_next = ptr;
                    wrdata_next    = IN_DATA;
                    ptr_inc        = 1'b1;
                    if (count != DEPTH_COUNT) begin
                        count_next = count + (ADDR_W+1)'(1);
                    end
                    if (!WRAP && (count_next == DEPTH_COUNT)) begin
                        full_next = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                wren_next      = 1'b1;
                wraddress_next = clr_idx;
                wrdata_next    = '0;
                idx_inc        = 1'b1;
                if (clr_idx == LAST_INDEX) begin
                    state_next     = ST_IDLE;
                    busy_next      = 1'b0;
                    ptr_load       = 1'b1;
                    ptr_load_value = '0;
                    count_next     = '0;
                    full_next      = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Write port is registered so the RAM sees each word one cycle after it is accepted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            WREN      <= 1'b0;
            WRADDRESS <= '0;
            WRDATA    <= '0;
            count     <= '0;
            full      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            WREN      <= wren_next;
            WRADDRESS <= wraddress_next;
            WRDATA    <= wrdata_next;
            count     <= count_next;
            full      <= full_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed bench for ram_stream_loader: a WRAP=0 and a WRAP=1 instance share
// the same stimulus so the full-stop and wrap-around behaviours run side by side.
module tb_ram_stream_loader;

    logic       CLK;
    logic       RESET;
    logic [7:0] in_data;
    logic       in_valid;
    logic       clear;
    logic       load_addr;
    logic [4:0] set_addr;

    logic       in_ready, wren, full, busy;
    logic [4:0] wraddress, ptr;
    logic [7:0] wrdata;
    logic [5:0] count;

    logic       w_in_ready, w_wren, w_full, w_busy;
    logic [4:0] w_wraddress, w_ptr;
    logic [7:0] w_wrdata;
    logic [5:0] w_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       load_addr;
        logic [4:0] set_addr;
        logic       exp_ready;
        logic       exp_wren;
        logic [4:0] exp_addr;
        logic [7:0] exp_data;
        logic [4:0] exp_ptr;
        logic [5:0] exp_count;
    } vector_t;

    vector_t vectors[9];

    ram_stream_loader #(.WRAP(1'b0)) dut (
        .CLK(CLK), .RESET(RESET), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(in_ready), .CLEAR(clear), .LOAD_ADDR(load_addr), .SET_ADDR(set_addr),
        .WRADDRESS(wraddress), .WRDATA(wrdata), .WREN(wren), .PTR(ptr),
        .COUNT(count), .FULL(full), .BUSY(busy)
    );

    ram_stream_loader #(.WRAP(1'b1)) dut_wrap (
        .CLK(CLK), .RESET(RESET), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(w_in_ready), .CLEAR(clear), .LOAD_ADDR(load_addr), .SET_ADDR(set_addr),
        .WRADDRESS(w_wraddress), .WRDATA(w_wrdata), .WREN(w_wren), .PTR(w_ptr),
        .COUNT(w_count), .FULL(w_full), .BUSY(w_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                 input logic clr, input logic load, input logic [4:0] addr);
        in_valid  = valid;
        in_data   = data;
        clear     = clr;
        load_addr = load;
        set_addr  = addr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expects the first CLEAR-state edge to have happened; walks all 32 fill writes.
    task automatic runFill(input string tag);
        for (int i = 0; i < 32; i++) begin
            if (i == 5) applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 5'd3);
            else        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
            #1;
            checkOutput({tag, "_fill_ready"}, 32'(in_ready), 32'd0);
            tick();
            checkOutput({tag, "_fill_wren"}, 32'(wren), 32'd1);
            checkOutput({tag, "_fill_addr"}, 32'(wraddress), 32'(i));
            checkOutput({tag, "_fill_data"}, 32'(wrdata), 32'd0);
            checkOutput({tag, "_fill_busy"}, 32'(busy), 32'(i < 31));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        #1;
        checkOutput({tag, "_post_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_post_ptr"},   32'(ptr),      32'd0);
        checkOutput({tag, "_post_count"}, 32'(count),    32'd0);
        checkOutput({tag, "_post_full"},  32'(full),     32'd0);
        tick();
        checkOutput({tag, "_post_wren"},  32'(wren),     32'd0);
    endtask

    initial begin
        //                in_valid data   load  set     ready wren addr   data   ptr    count
        vectors[0] = '{1'b1, 8'hA0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  8'hA0, 5'd1,  6'd1};
        vectors[1] = '{1'b1, 8'hA1, 1'b0, 5'd0,  1'b1, 1'b1, 5'd1,  8'hA1, 5'd2,  6'd2};
        vectors[2] = '{1'b1, 8'hA2, 1'b0, 5'd0,  1'b1, 1'b1, 5'd2,  8'hA2, 5'd3,  6'd3};
        vectors[3] = '{1'b1, 8'hA3, 1'b0, 5'd0,  1'b1, 1'b1, 5'd3,  8'hA3, 5'd4,  6'd4};
        vectors[4] = '{1'b1, 8'hA4, 1'b0, 5'd0,  1'b1, 1'b1, 5'd4,  8'hA4, 5'd5,  6'd5};
        vectors[5] = '{1'b0, 8'h00, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  8'h00, 5'd5,  6'd5};
        vectors[6] = '{1'b1, 8'h77, 1'b1, 5'h1C, 1'b0, 1'b0, 5'd0,  8'h00, 5'h1C, 6'd5};
        vectors[7] = '{1'b1, 8'h55, 1'b0, 5'd0,  1'b1, 1'b1, 5'h1C, 8'h55, 5'h1D, 6'd6};
        vectors[8] = '{1'b0, 8'h00, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  8'h00, 5'h1D, 6'd6};

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        checkOutput("rst_wren",  32'(wren),      32'd0);
        checkOutput("rst_addr",  32'(wraddress), 32'd0);
        checkOutput("rst_data",  32'(wrdata),    32'd0);
        checkOutput("rst_ptr",   32'(ptr),       32'd0);
        checkOutput("rst_count", 32'(count),     32'd0);
        checkOutput("rst_full",  32'(full),      32'd0);
        checkOutput("rst_busy",  32'(busy),      32'd0);
        checkOutput("rst_ready", 32'(in_ready),  32'd1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i].in_valid, vectors[i].in_data, 1'b0,
                          vectors[i].load_addr, vectors[i].set_addr);
            #1;
            checkOutput($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vectors[i].exp_ready));
            tick();
            checkOutput($sformatf("vec%0d_wren", i), 32'(wren), 32'(vectors[i].exp_wren));
            if (vectors[i].exp_wren) begin
                checkOutput($sformatf("vec%0d_addr", i), 32'(wraddress), 32'(vectors[i].exp_addr));
                checkOutput($sformatf("vec%0d_data", i), 32'(wrdata), 32'(vectors[i].exp_data));
            end
            checkOutput($sformatf("vec%0d_ptr", i), 32'(ptr), 32'(vectors[i].exp_ptr));
            checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vectors[i].exp_count));
            checkOutput($sformatf("vec%0d_full", i), 32'(full), 32'd0);
        end

        // 34 bytes: the WRAP=0 copy stops at 32, the WRAP=1 copy wraps onto 0 and 1.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 34; i++) begin
            applyStimulus(1'b1, 8'(i + 8'h10), 1'b0, 1'b0, 5'd0);
            #1;
            checkOutput("stream_ready", 32'(in_ready), 32'(i < 32));
            checkOutput("wrap_ready", 32'(w_in_ready), 32'd1);
            tick();
            checkOutput("stream_wren", 32'(wren), 32'(i < 32));
            if (i < 32) begin
                checkOutput("stream_addr", 32'(wraddress), 32'(i));
                checkOutput("stream_data", 32'(wrdata), 32'(i + 16));
            end
            checkOutput("stream_full", 32'(full), 32'(i >= 31));
            checkOutput("stream_count", 32'(count), 32'((i >= 31) ? 32 : i + 1));
            checkOutput("wrap_wren", 32'(w_wren), 32'd1);
            checkOutput("wrap_addr", 32'(w_wraddress), 32'(i % 32));
            checkOutput("wrap_data", 32'(w_wrdata), 32'(i + 16));
            checkOutput("wrap_count", 32'(w_count), 32'((i >= 31) ? 32 : i + 1));
            checkOutput("wrap_full", 32'(w_full), 32'd0);
            if (i == 31) checkOutput("full_ptr", 32'(ptr), 32'd0);
        end
        checkOutput("wrap_ptr", 32'(w_ptr), 32'd2);
        checkOutput("stream_ptr_held", 32'(ptr), 32'd0);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 5'd7);
        tick();
        checkOutput("load_full_ptr", 32'(ptr), 32'd7);
        checkOutput("load_full_kept", 32'(full), 32'd1);
        checkOutput("load_full_wren", 32'(wren), 32'd0);

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 5'd0);
        #1;
        checkOutput("clr_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("clr_busy", 32'(busy), 32'd1);
        checkOutput("clr_first_wren", 32'(wren), 32'd0);
        runFill("fromfull");

        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 5'd0);
        #1;
        checkOutput("clrval_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("clrval_busy", 32'(busy), 32'd1);
        checkOutput("clrval_wren", 32'(wren), 32'd0);
        checkOutput("clrval_count", 32'(count), 32'd0);
        runFill("clrval");

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        repeat (10) tick();
        checkOutput("abort_pre_addr", 32'(wraddress), 32'd9);
        checkOutput("abort_pre_busy", 32'(busy), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checkOutput("abort_busy",  32'(busy),     32'd0);
        checkOutput("abort_wren",  32'(wren),     32'd0);
        checkOutput("abort_ptr",   32'(ptr),      32'd0);
        checkOutput("abort_count", 32'(count),    32'd0);
        checkOutput("abort_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("abort_idle_wren", 32'(wren), 32'd0);
        checkOutput("abort_idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
